game_round_controller: RTL and testbench

- Sequences one game of the shape-guessing lab and consumes the outputs of the grading stage (checkForZood/checkForZnarly).
- Enables master-pattern loading, turns the player's grade button into a one-cycle check request, and latches the returned Znarly/Zood counts.
- Counts rounds and declares the game won or lost.

---
 rtl/lab5_pkg.sv | 17 +
 rtl/score_history.sv | 23 ++
 rtl/game_round_controller.sv | 152 +++++++++++++++
 tb/tb_game_round_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lab5_pkg.sv
// Shared constants and types for the shape-guessing lab round controller.
package lab5_pkg;
    localparam int SHAPE_BITS   = 3;
    localparam int NUM_SHAPES   = 4;
    localparam int PATTERN_BITS = 12;

    typedef logic [3:0] count_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        CHECK,
        WAIT,
        DONE
    } game_state_t;
endpackage

// File: rtl/score_history.sv
// 16-entry x 8-bit score history ({Znarly, Zood}); used only with SCORE_HISTORY_EN.
module score_history (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);
    logic [15:0][7:0] mem_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            mem_q <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/game_round_controller.sv
// Sequences one game: master load, per-round grade request, score latch, win/loss.
// Optional score history storage under macro SCORE_HISTORY_EN.
module game_round_controller #(
    parameter int NUM_ROUNDS = 8,
    parameter int NUM_SHAPES = lab5_pkg::NUM_SHAPES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startGame,
    input  logic       masterLoaded,
    input  logic       gradeIt,
    input  logic       scoreValid,
    input  logic [3:0] Znarly,
    input  logic [3:0] Zood,
    output logic       loadEnable,
    output logic       check,
    output logic [3:0] roundNumber,
    output logic [3:0] lastZnarly,
    output logic [3:0] lastZood,
    output logic       scoreError,
    output logic       gameWon,
    output logic       gameOver,
    input  logic [3:0] histIndex,
    output logic [3:0] histZnarly,
    output logic [3:0] histZood
);
    import lab5_pkg::*;

    localparam count_t     ROUNDS_C = count_t'(NUM_ROUNDS);
    localparam count_t     SHAPES_C = count_t'(NUM_SHAPES);
    localparam logic [4:0] SHAPES5  = 5'(NUM_SHAPES);

    game_state_t state_q, state_d;
    count_t      round_q, round_d;
    count_t      zn_q, zn_d;
    count_t      zo_q, zo_d;
    logic        won_q, won_d;
    logic        over_q, over_d;
    logic        err_q, err_d;
    logic [4:0]  score_sum;
    logic        illegal;
    logic        accept;

    // Sum is taken 5 bits wide so 15+15 cannot wrap into a legal value.
    assign score_sum = {1'b0, Znarly} + {1'b0, Zood};
    assign illegal   = score_sum > SHAPES5;
    assign accept    = (state_q == WAIT) && scoreValid && !illegal && !startGame;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            zn_q    <= '0;
            zo_q    <= '0;
            won_q   <= 1'b0;
            over_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            zn_q    <= zn_d;
            zo_q    <= zo_d;
            won_q   <= won_d;
            over_q  <= over_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        zn_d    = zn_q;
        zo_d    = zo_q;
        won_d   = won_q;
        over_d  = over_q;
        err_d   = 1'b0;
        // A restart wins over everything, including a score arriving this cycle.
        if (startGame) begin
            state_d = LOAD;
            round_d = '0;
            zn_d    = '0;
            zo_d    = '0;
            won_d   = 1'b0;
            over_d  = 1'b0;
        end else begin
            case (state_q)
                LOAD: if (masterLoaded) begin
                    state_d = PLAY;
                    round_d = 4'd1;
                end
                PLAY:  if (gradeIt) state_d = CHECK;
                CHECK: state_d = WAIT;
                WAIT: if (scoreValid) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        zn_d = Znarly;
                        zo_d = Zood;
                        if (Znarly == SHAPES_C) begin
                            state_d = DONE;
                            won_d   = 1'b1;
                            over_d  = 1'b1;
                        end else if (round_q == ROUNDS_C) begin
                            state_d = DONE;
                            over_d  = 1'b1;
                        end else begin
                            state_d = PLAY;
                            round_d = round_q + 4'd1;
                        end
                    end
                end
                IDLE, DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        loadEnable = (state_q == LOAD);
        check      = (state_q == CHECK);
    end

    assign roundNumber = round_q;
    assign lastZnarly  = zn_q;
    assign lastZood    = zo_q;
    assign scoreError  = err_q;
    assign gameWon     = won_q;
    assign gameOver    = over_q;

`ifdef SCORE_HISTORY_EN
    logic [7:0] hist_rdata;

    score_history u_hist (
        .clock (clock),
        .reset (reset),
        .clear (startGame),
        .we    (accept),
        .waddr (round_q - 4'd1),
        .wdata ({Znarly, Zood}),
        .raddr (histIndex),
        .rdata (hist_rdata)
    );

    assign histZnarly = (histIndex < round_q) ? hist_rdata[7:4] : 4'd0;
    assign histZood   = (histIndex < round_q) ? hist_rdata[3:0] : 4'd0;
`else
    logic unused_hist;
    assign unused_hist = ^{histIndex, accept};
    assign histZnarly  = 4'd0;
    assign histZood    = 4'd0;
`endif
endmodule

// File: tb/tb_game_round_controller.sv
// Directed self-checking bench for game_round_controller (default build).
module tb_game_round_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       startGame = 1'b0;
    logic       masterLoaded = 1'b0;
    logic       gradeIt = 1'b0;
    logic       scoreValid = 1'b0;
    logic [3:0] Znarly = '0;
    logic [3:0] Zood = '0;
    logic [3:0] histIndex = '0;
    logic       loadEnable, check, scoreError, gameWon, gameOver;
    logic [3:0] roundNumber, lastZnarly, lastZood, histZnarly, histZood;

    int n_checks = 0;
    int n_fail   = 0;

    game_round_controller #(.NUM_ROUNDS(8), .NUM_SHAPES(4)) dut (
        .clock(clock), .reset(reset), .startGame(startGame),
        .masterLoaded(masterLoaded), .gradeIt(gradeIt), .scoreValid(scoreValid),
        .Znarly(Znarly), .Zood(Zood), .loadEnable(loadEnable), .check(check),
        .roundNumber(roundNumber), .lastZnarly(lastZnarly), .lastZood(lastZood),
        .scoreError(scoreError), .gameWon(gameWon), .gameOver(gameOver),
        .histIndex(histIndex), .histZnarly(histZnarly), .histZood(histZood)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_round(input logic [3:0] zn, input logic [3:0] zo);
        gradeIt = 1'b1; step();
        gradeIt = 1'b0; step();
        scoreValid = 1'b1; Znarly = zn; Zood = zo; step();
        scoreValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; startGame = 1'b1; step();
        reset = 1'b0; startGame = 1'b0;
        n_checks += 9;
        if (roundNumber !== 4'd0) begin n_fail++; $display("FAIL reset_round got %0d exp 0", roundNumber); end
        if (lastZnarly !== 4'd0) begin n_fail++; $display("FAIL reset_znarly got %0d exp 0", lastZnarly); end
        if (lastZood !== 4'd0) begin n_fail++; $display("FAIL reset_zood got %0d exp 0", lastZood); end
        if (gameWon !== 1'b0) begin n_fail++; $display("FAIL reset_won got %b exp 0", gameWon); end
        if (gameOver !== 1'b0) begin n_fail++; $display("FAIL reset_over got %b exp 0", gameOver); end
        if (check !== 1'b0) begin n_fail++; $display("FAIL reset_check got %b exp 0", check); end
        if (loadEnable !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b exp 0", loadEnable); end
        if (scoreError !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", scoreError); end
        if (histZnarly !== 4'd0) begin n_fail++; $display("FAIL reset_hist got %0d exp 0", histZnarly); end
        step();
        n_checks++;
        if (loadEnable !== 1'b0) begin n_fail++; $display("FAIL idle_hold_load got %b exp 0", loadEnable); end
    endtask

    task automatic test_start_load();
        startGame = 1'b1; step();
        startGame = 1'b0;
        n_checks += 2;
        if (loadEnable !== 1'b1) begin n_fail++; $display("FAIL start_load got %b exp 1", loadEnable); end
        if (roundNumber !== 4'd0) begin n_fail++; $display("FAIL start_round got %0d exp 0", roundNumber); end
        step();
        n_checks++;
        if (loadEnable !== 1'b1) begin n_fail++; $display("FAIL load_hold got %b exp 1", loadEnable); end
        masterLoaded = 1'b1; step();
        masterLoaded = 1'b0;
        n_checks += 2;
        if (roundNumber !== 4'd1) begin n_fail++; $display("FAIL loaded_round got %0d exp 1", roundNumber); end
        if (loadEnable !== 1'b0) begin n_fail++; $display("FAIL loaded_load got %b exp 0", loadEnable); end
    endtask

    task automatic test_grade_hold();
        int nchk = 0;
        gradeIt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin
                n_checks++;
                if (check !== 1'b1) begin n_fail++; $display("FAIL grade_first_check got %b exp 1", check); end
            end
            if (check === 1'b1) nchk++;
        end
        gradeIt = 1'b0;
        n_checks++;
        if (nchk != 1) begin n_fail++; $display("FAIL grade_hold_count got %0d exp 1", nchk); end
    endtask

    task automatic test_win();
        // Still in WAIT for round 1 from the held-grade scenario.
        scoreValid = 1'b1; Znarly = 4'd1; Zood = 4'd2; step();
        scoreValid = 1'b0;
        n_checks += 4;
        if (roundNumber !== 4'd2) begin n_fail++; $display("FAIL win_r1_round got %0d exp 2", roundNumber); end
        if (lastZnarly !== 4'd1) begin n_fail++; $display("FAIL win_r1_zn got %0d exp 1", lastZnarly); end
        if (lastZood !== 4'd2) begin n_fail++; $display("FAIL win_r1_zo got %0d exp 2", lastZood); end
        if (gameOver !== 1'b0) begin n_fail++; $display("FAIL win_r1_over got %b exp 0", gameOver); end
        do_round(4'd2, 4'd1);
        n_checks += 2;
        if (roundNumber !== 4'd3) begin n_fail++; $display("FAIL win_r2_round got %0d exp 3", roundNumber); end
        if (lastZood !== 4'd1) begin n_fail++; $display("FAIL win_r2_zo got %0d exp 1", lastZood); end
        do_round(4'd4, 4'd0);
        n_checks += 4;
        if (gameWon !== 1'b1) begin n_fail++; $display("FAIL win_won got %b exp 1", gameWon); end
        if (gameOver !== 1'b1) begin n_fail++; $display("FAIL win_over got %b exp 1", gameOver); end
        if (lastZnarly !== 4'd4) begin n_fail++; $display("FAIL win_zn got %0d exp 4", lastZnarly); end
        if (roundNumber !== 4'd3) begin n_fail++; $display("FAIL win_round got %0d exp 3", roundNumber); end
        gradeIt = 1'b1; step(); step();
        gradeIt = 1'b0;
        n_checks += 2;
        if (check !== 1'b0) begin n_fail++; $display("FAIL done_check got %b exp 0", check); end
        if (gameWon !== 1'b1) begin n_fail++; $display("FAIL done_hold_won got %b exp 1", gameWon); end
    endtask

    task automatic test_loss();
        int nchk = 0;
        startGame = 1'b1; step();
        startGame = 1'b0;
        n_checks += 2;
        if (gameWon !== 1'b0) begin n_fail++; $display("FAIL loss_restart_won got %b exp 0", gameWon); end
        if (roundNumber !== 4'd0) begin n_fail++; $display("FAIL loss_restart_round got %0d exp 0", roundNumber); end
        masterLoaded = 1'b1; step();
        masterLoaded = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            do_round(4'd0, 4'd3);
            if (r == 7) begin
                n_checks += 2;
                if (roundNumber !== 4'd8) begin n_fail++; $display("FAIL loss_r7_round got %0d exp 8", roundNumber); end
                if (gameOver !== 1'b0) begin n_fail++; $display("FAIL loss_r7_over got %b exp 0", gameOver); end
            end
        end
        n_checks += 4;
        if (gameOver !== 1'b1) begin n_fail++; $display("FAIL loss_over got %b exp 1", gameOver); end
        if (gameWon !== 1'b0) begin n_fail++; $display("FAIL loss_won got %b exp 0", gameWon); end
        if (roundNumber !== 4'd8) begin n_fail++; $display("FAIL loss_round got %0d exp 8", roundNumber); end
        if (lastZood !== 4'd3) begin n_fail++; $display("FAIL loss_zo got %0d exp 3", lastZood); end
        gradeIt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (check === 1'b1) nchk++;
        end
        gradeIt = 1'b0;
        n_checks++;
        if (nchk != 0) begin n_fail++; $display("FAIL loss_no_check got %0d exp 0", nchk); end
    endtask

    task automatic test_illegal();
        startGame = 1'b1; step();
        startGame = 1'b0; masterLoaded = 1'b1; step();
        masterLoaded = 1'b0;
        scoreValid = 1'b1; Znarly = 4'd2; Zood = 4'd1; step();
        scoreValid = 1'b0;
        n_checks += 2;
        if (lastZnarly !== 4'd0) begin n_fail++; $display("FAIL play_score_zn got %0d exp 0", lastZnarly); end
        if (roundNumber !== 4'd1) begin n_fail++; $display("FAIL play_score_round got %0d exp 1", roundNumber); end
        gradeIt = 1'b1; step();
        gradeIt = 1'b0; scoreValid = 1'b1; step();
        scoreValid = 1'b0;
        n_checks++;
        if (lastZnarly !== 4'd0) begin n_fail++; $display("FAIL check_score_zn got %0d exp 0", lastZnarly); end
        scoreValid = 1'b1; Znarly = 4'd3; Zood = 4'd2; step();
        scoreValid = 1'b0;
        n_checks += 3;
        if (scoreError !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", scoreError); end
        if (lastZnarly !== 4'd0) begin n_fail++; $display("FAIL illegal_zn got %0d exp 0", lastZnarly); end
        if (roundNumber !== 4'd1) begin n_fail++; $display("FAIL illegal_round got %0d exp 1", roundNumber); end
        step();
        n_checks++;
        if (scoreError !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b exp 0", scoreError); end
        scoreValid = 1'b1; Znarly = 4'd3; Zood = 4'd1; step();
        scoreValid = 1'b0;
        n_checks += 4;
        if (lastZnarly !== 4'd3) begin n_fail++; $display("FAIL legal_zn got %0d exp 3", lastZnarly); end
        if (lastZood !== 4'd1) begin n_fail++; $display("FAIL legal_zo got %0d exp 1", lastZood); end
        if (roundNumber !== 4'd2) begin n_fail++; $display("FAIL legal_round got %0d exp 2", roundNumber); end
        if (scoreError !== 1'b0) begin n_fail++; $display("FAIL legal_err got %b exp 0", scoreError); end
    endtask

    task automatic test_restart();
        do_round(4'd1, 4'd1);
        n_checks++;
        if (roundNumber !== 4'd3) begin n_fail++; $display("FAIL restart_pre_round got %0d exp 3", roundNumber); end
        gradeIt = 1'b1; step();
        gradeIt = 1'b0; step();
        startGame = 1'b1; scoreValid = 1'b1; Znarly = 4'd4; Zood = 4'd0; histIndex = 4'd0; step();
        startGame = 1'b0; scoreValid = 1'b0;
        n_checks += 6;
        if (loadEnable !== 1'b1) begin n_fail++; $display("FAIL restart_load got %b exp 1", loadEnable); end
        if (roundNumber !== 4'd0) begin n_fail++; $display("FAIL restart_round got %0d exp 0", roundNumber); end
        if (gameWon !== 1'b0) begin n_fail++; $display("FAIL restart_won got %b exp 0", gameWon); end
        if (gameOver !== 1'b0) begin n_fail++; $display("FAIL restart_over got %b exp 0", gameOver); end
        if (lastZnarly !== 4'd0) begin n_fail++; $display("FAIL restart_zn got %0d exp 0", lastZnarly); end
        if (histZnarly !== 4'd0) begin n_fail++; $display("FAIL restart_hist got %0d exp 0", histZnarly); end
        masterLoaded = 1'b1; step();
        masterLoaded = 1'b0; startGame = 1'b1; step();
        startGame = 1'b0;
        n_checks += 2;
        if (loadEnable !== 1'b1) begin n_fail++; $display("FAIL abort_play_load got %b exp 1", loadEnable); end
        if (roundNumber !== 4'd0) begin n_fail++; $display("FAIL abort_play_round got %0d exp 0", roundNumber); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_start_load();
        test_grade_hold();
        test_win();
        test_loss();
        test_illegal();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
